// File: rtl/fs_port_arbiter.sv
// fs_port_arbiter: round-robin owner lock for the single filesystem port.
//
// Handshake: a requester raises req_access[k] and holds it for its whole
// transaction. It may rely on its fs enables/fields only while grant[k] is
// high; anything it drives while ungranted is discarded. Dropping access ends
// the transaction. A one-cycle idle gap with all fs outputs at 0 always
// follows an owner, so the filesystem sees filename 0 and restarts its open
// sequence. A grant held for MAX_HOLD cycles is revoked. The revoked requester
// gets a sticky timeout flag and stays blocked until it drops access.
module fs_port_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAX_HOLD = 65535,
  parameter int CW       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_access,
  input  logic [NREQ-1:0]      req_rden,
  input  logic [NREQ-1:0]      req_wren,
  input  logic [32*NREQ-1:0]   req_filename,
  input  logic [32*NREQ-1:0]   req_address,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic [31:0]          req_q,
  output logic [NREQ-1:0]      timeout,
  output logic                 fsRden,
  output logic                 fsWren,
  output logic [31:0]          fsFilename,
  output logic [31:0]          fsAddress,
  output logic [31:0]          fsData,
  input  logic [31:0]          fsQ,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_timeout;
  logic [NREQ-1:0] r_blocked;
  logic [1:0]      r_rr_ptr;
  logic [CW-1:0]   r_hold_cnt;

  logic [NREQ-1:0] w_eligible;
  logic            w_win_found;
  logic [NREQ-1:0] w_win_onehot;
  logic            w_owner_access;
  logic [1:0]      w_next_ptr;
  logic            w_wd_hit;
  logic            w_do_grant;
  logic            w_do_release;
  logic            w_do_revoke;

  assign w_eligible  = req_access & ~r_blocked;
  assign w_wd_hit    = (MAX_HOLD != 0) && (r_hold_cnt == CW'(MAX_HOLD - 1));
  assign grant       = r_grant;
  assign timeout     = r_timeout;
  assign req_q       = fsQ;
  assign o_dbg_state = r_state;

  // Round-robin pick: first eligible requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_win_found  = 1'b0;
    w_win_onehot = '0;
    for (int off = 0; off < NREQ; off++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_win_found && (k == ((int'(r_rr_ptr) + off) % NREQ)) && w_eligible[k]) begin
          w_win_found     = 1'b1;
          w_win_onehot[k] = 1'b1;
        end
      end
    end
  end

  // Owner's access level and the pointer just past the owner.
  always_comb begin
    w_owner_access = 1'b0;
    w_next_ptr     = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant[k]) begin
        w_owner_access = req_access[k];
        w_next_ptr     = 2'((k + 1) % NREQ);
      end
    end
  end

  // FSM next state and the one-cycle action strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_do_grant   = 1'b0;
    w_do_release = 1'b0;
    w_do_revoke  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_found) begin
          w_do_grant  = 1'b1;
          w_state_nxt = ST_OWN;
        end
      end
      ST_OWN: begin
        // A drop on the same cycle as the limit is an ordinary release.
        if (!w_owner_access) begin
          w_do_release = 1'b1;
          w_state_nxt  = ST_GAP;
        end else if (w_wd_hit) begin
          w_do_revoke = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant, pointer, watchdog counter and the timeout/blocked flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= '0;
      r_timeout  <= '0;
      r_blocked  <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_blocked <= r_blocked & req_access;
      if (w_do_grant) begin
        r_grant    <= w_win_onehot;
        r_hold_cnt <= '0;
        r_timeout  <= r_timeout & ~w_win_onehot;
      end else if (w_do_release) begin
        r_grant  <= '0;
        r_rr_ptr <= w_next_ptr;
      end else if (w_do_revoke) begin
        r_grant   <= '0;
        r_rr_ptr  <= w_next_ptr;
        r_timeout <= r_timeout | r_grant;
        r_blocked <= (r_blocked & req_access) | r_grant;
      end
      if ((r_state == ST_OWN) && (r_hold_cnt != {CW{1'b1}})) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  // fs port mux: granted requester's fields, all zero when nobody owns it.
  always_comb begin
    fsRden     = 1'b0;
    fsWren     = 1'b0;
    fsFilename = '0;
    fsAddress  = '0;
    fsData     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant[k]) begin
        fsRden     = req_rden[k];
        fsWren     = req_wren[k];
        fsFilename = req_filename[32*k +: 32];
        fsAddress  = req_address[32*k +: 32];
        fsData     = req_data[32*k +: 32];
      end
    end
  end

endmodule

// File: tb/tb_fs_port_arbiter.sv
// tb_fs_port_arbiter: vector table plus hand sequences for fs_port_arbiter.
module tb_fs_port_arbiter;

  localparam int NREQ     = 2;
  localparam int MAX_HOLD = 8;
  localparam int CW       = 16;
  localparam int W        = 134;  // {grant, timeout, rden, wren, fn, addr, data, q}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_access, req_rden, req_wren;
  logic [31:0]        fn [2];
  logic [31:0]        ad [2];
  logic [31:0]        da [2];
  logic [32*NREQ-1:0] req_filename, req_address, req_data;
  logic [NREQ-1:0]    grant, timeout;
  logic [31:0]        req_q, fsFilename, fsAddress, fsData, fs_q;
  logic               fsRden, fsWren;
  logic [1:0]         dbg_state;

  assign req_filename = {fn[1], fn[0]};
  assign req_address  = {ad[1], ad[0]};
  assign req_data     = {da[1], da[0]};

  fs_port_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_access(req_access), .req_rden(req_rden), .req_wren(req_wren),
    .req_filename(req_filename), .req_address(req_address), .req_data(req_data),
    .grant(grant), .req_q(req_q), .timeout(timeout),
    .fsRden(fsRden), .fsWren(fsWren),
    .fsFilename(fsFilename), .fsAddress(fsAddress), .fsData(fsData),
    .fsQ(fs_q), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run    = 0;
  int           tests_failed = 0;

  // Expected outputs from what the bench itself is driving.
  function automatic logic [W-1:0] mk_exp(input logic [1:0] g, input logic [1:0] to);
    logic rd, wr;
    logic [31:0] f, a, d;
    rd = 1'b0; wr = 1'b0; f = '0; a = '0; d = '0;
    if (g == 2'b01) begin
      rd = req_rden[0]; wr = req_wren[0]; f = fn[0]; a = ad[0]; d = da[0];
    end else if (g == 2'b10) begin
      rd = req_rden[1]; wr = req_wren[1]; f = fn[1]; a = ad[1]; d = da[1];
    end
    return {g, to, rd, wr, f, a, d, fs_q};
  endfunction

  task automatic expect_out(input string nm, input logic [1:0] g, input logic [1:0] to);
    exp_q.push_back(mk_exp(g, to));
    name_q.push_back(nm);
  endtask

  task automatic expect_vec(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic compare_front();
    logic [W-1:0] act, e;
    string nm;
    act = {grant, timeout, fsRden, fsWren, fsFilename, fsAddress, fsData, req_q};
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard_underflow: got %h required an expected entry", act);
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    if (act !== e) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h (fields grant,timeout,rden,wren,fn,addr,data,q)", nm, act, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_neg();
    @(negedge clk);
    compare_front();
  endtask

  task automatic clear_fields();
    req_rden = '0; req_wren = '0;
    for (int k = 0; k < 2; k++) begin
      fn[k] = '0; ad[k] = '0; da[k] = '0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rden0, wren0;
    logic [31:0] fn0, ad0, da0, q;
    logic        exp_rden, exp_wren;
    logic [31:0] exp_fn, exp_ad, exp_da, exp_q;
  } vec_t;

  vec_t vt [6];

  logic [1:0] acc_s [17] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11,
                             2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
  logic [1:0] g_s   [17] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01,
                             2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

  // Run-time bound on the whole test.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test required finish within 200000 time units");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    logic [1:0] g_e, to_e;

    vt[0] = '{1'b1, 1'b0, 32'h2F746D70, 32'h00000000, 32'h00000000, 32'hDEADBEEF,
              1'b1, 1'b0, 32'h2F746D70, 32'h00000000, 32'h00000000, 32'hDEADBEEF};
    vt[1] = '{1'b0, 1'b1, 32'h2F746D70, 32'h00000004, 32'hCAFEF00D, 32'hDEADBEEF,
              1'b0, 1'b1, 32'h2F746D70, 32'h00000004, 32'hCAFEF00D, 32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 32'h2F62696E, 32'hFFFFFFFC, 32'h12345678, 32'h00000000,
              1'b1, 1'b1, 32'h2F62696E, 32'hFFFFFFFC, 32'h12345678, 32'h00000000};
    vt[3] = '{1'b0, 1'b0, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
              1'b0, 1'b0, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[4] = '{1'b1, 1'b0, 32'h2F746D70, 32'h00000010, 32'h00000000, 32'hDEADBEEF,
              1'b1, 1'b0, 32'h2F746D70, 32'h00000010, 32'h00000000, 32'hDEADBEEF};
    vt[5] = '{1'b0, 1'b1, 32'h2F746D70, 32'h00000014, 32'hA5A5A5A5, 32'h5A5A5A5A,
              1'b0, 1'b1, 32'h2F746D70, 32'h00000014, 32'hA5A5A5A5, 32'h5A5A5A5A};

    // ---- reset with both requesting and all fields high ----
    rst_n = 1'b0;
    req_access = 2'b11; req_rden = 2'b11; req_wren = 2'b11;
    for (int k = 0; k < 2; k++) begin
      fn[k] = 32'hFFFFFFFF; ad[k] = 32'hFFFFFFFF; da[k] = 32'hFFFFFFFF;
    end
    fs_q = 32'h12345678;
    tick(); expect_out("reset_hold_a", 2'b00, 2'b00); check_neg();
    tick(); expect_out("reset_hold_b", 2'b00, 2'b00); check_neg();
    tick(); rst_n = 1'b1;
    tick(); tick();
    expect_out("reset_release_grant", 2'b01, 2'b00); check_neg();

    // ---- release, then req1 wins from rr_ptr=1, then async reset ----
    fn[1] = 32'h5A5A5A5A; ad[1] = 32'h00001234; da[1] = 32'h0BADF00D;
    tick(); req_access = 2'b00;
    tick(); expect_out("release_gap", 2'b00, 2'b00); check_neg();
    req_access = 2'b11;
    tick(); expect_out("gap_to_idle", 2'b00, 2'b00); check_neg();
    tick(); expect_out("rr_grant_req1", 2'b10, 2'b00); check_neg();
    rst_n = 1'b0;
    #1;
    expect_out("mid_reset_async", 2'b00, 2'b00); compare_front();
    tick(); tick(); rst_n = 1'b1;
    tick(); expect_out("rr_ptr_after_reset", 2'b01, 2'b00); check_neg();
    req_access = 2'b00;
    tick(); expect_out("release_after_reset", 2'b00, 2'b00); check_neg();
    tick(); expect_out("idle_after_gap", 2'b00, 2'b00); check_neg();

    // ---- single owner: two filenames, then gap forces zeros ----
    clear_fields(); fs_q = 32'h0;
    req_access = 2'b01; req_rden = 2'b01; fn[0] = 32'h2F646576; ad[0] = 32'h100; da[0] = 32'h11;
    fn[1] = 32'h77777777;
    tick(); expect_out("single_fn_dev", 2'b01, 2'b00); check_neg();
    req_rden = 2'b00; req_wren = 2'b01; fn[0] = 32'h2F6D656D;
    tick(); expect_out("single_fn_mem", 2'b01, 2'b00); check_neg();
    req_access = 2'b00;
    tick(); expect_out("single_gap_zero", 2'b00, 2'b00); check_neg();
    tick(); expect_out("single_idle", 2'b00, 2'b00); check_neg();

    // ---- isolation table: req0 owns, req1 drives noise ----
    req_access = 2'b01;
    for (int i = 0; i < 6; i++) begin
      req_rden[0] = vt[i].rden0; req_wren[0] = vt[i].wren0;
      fn[0] = vt[i].fn0; ad[0] = vt[i].ad0; da[0] = vt[i].da0; fs_q = vt[i].q;
      req_rden[1] = 1'($urandom_range(0, 1)); req_wren[1] = 1'($urandom_range(0, 1));
      fn[1] = $urandom; ad[1] = $urandom; da[1] = $urandom;
      tick();
      expect_vec($sformatf("iso_vec%0d", i),
                 {2'b01, 2'b00, vt[i].exp_rden, vt[i].exp_wren, vt[i].exp_fn,
                  vt[i].exp_ad, vt[i].exp_da, vt[i].exp_q});
      check_neg();
    end
    req_access = 2'b00;
    tick(); expect_out("iso_release", 2'b00, 2'b00); check_neg();
    tick(); expect_out("iso_idle", 2'b00, 2'b00); check_neg();

    // ---- contention: 5-cycle transactions, round-robin alternation ----
    clear_fields(); fs_q = 32'h0;
    fn[0] = 32'hA0A0A0A0; fn[1] = 32'hB1B1B1B1; ad[0] = 32'h10; ad[1] = 32'h20;
    for (int i = 0; i < 17; i++) begin
      req_access = acc_s[i];
      tick();
      expect_out($sformatf("rr_cycle%0d", i + 1), g_s[i], 2'b00);
      check_neg();
    end

    // ---- watchdog: req1 holds 20 cycles, revoked after 8 granted cycles ----
    fn[1] = 32'hC0C0C0C0;
    for (int i = 1; i <= 24; i++) begin
      req_access = ((i <= 20) || (i == 22)) ? 2'b10 : 2'b00;
      g_e  = (((i >= 1) && (i <= 8)) || (i == 22)) ? 2'b10 : 2'b00;
      to_e = ((i >= 9) && (i <= 21)) ? 2'b10 : 2'b00;
      tick();
      expect_out($sformatf("wd_cycle%0d", i), g_e, to_e);
      check_neg();
    end

    // ---- drop on the limit cycle is a normal release ----
    for (int i = 1; i <= 10; i++) begin
      req_access = (i <= 8) ? 2'b01 : 2'b00;
      g_e = (i <= 8) ? 2'b01 : 2'b00;
      tick();
      expect_out($sformatf("limit_drop%0d", i), g_e, 2'b00);
      check_neg();
    end

    // ---- final report ----
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
